// File: rtl/cardinal_nic.sv
// Network interface between one cardinal_cpu core and its router port; optional NIC_POLARITY_EN gates injection on router phase.
// Latency: CPU reads return on d_out one cycle after nicEn is sampled; packets cross in one edge each way.
// Backpressure: net_ri drops while the input buffer is full; net_so waits for net_ro (and the matching phase when enabled).
module cardinal_nic (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic [0:63] d_in,
    output logic [0:63] d_out,
    input  logic        nicEn,
    input  logic        nicWrEn,
    input  logic        net_si,
    output logic        net_ri,
    input  logic [0:63] net_di,
    output logic        net_so,
    input  logic        net_ro,
    output logic [0:63] net_do,
    input  logic        net_polarity
);

    localparam logic [1:0] ADDR_IN_BUF  = 2'b00;
    localparam logic [1:0] ADDR_IN_STS  = 2'b01;
    localparam logic [1:0] ADDR_OUT_BUF = 2'b10;
    localparam logic [1:0] ADDR_OUT_STS = 2'b11;

    logic [0:63] in_buf_q,  in_buf_d;
    logic        in_full_q, in_full_d;
    logic [0:63] out_buf_q, out_buf_d;
    logic        out_full_q, out_full_d;
    logic [0:63] d_out_q,   d_out_d;

    logic cpu_rd;
    logic cpu_wr;
    logic vc_ok;

    assign cpu_rd = nicEn && !nicWrEn;
    assign cpu_wr = nicEn && nicWrEn;

`ifdef NIC_POLARITY_EN
    // Packet bit 0 selects the VC; inject only when the router is in that phase.
    assign vc_ok = (out_buf_q[0] == net_polarity);
`else
    logic unused_polarity;
    assign unused_polarity = net_polarity;
    assign vc_ok           = 1'b1;
`endif

    assign net_ri = !in_full_q;
    assign net_so = out_full_q && net_ro && vc_ok;
    assign net_do = out_buf_q;
    assign d_out  = d_out_q;

    always_comb begin
        in_buf_d   = in_buf_q;
        in_full_d  = in_full_q;
        out_buf_d  = out_buf_q;
        out_full_d = out_full_q;
        d_out_d    = d_out_q;

        if (cpu_rd) begin
            case (addr)
                ADDR_IN_BUF: begin
                    d_out_d   = in_buf_q;
                    in_full_d = 1'b0;
                end
                ADDR_IN_STS:  d_out_d = {63'b0, in_full_q};
                ADDR_OUT_BUF: d_out_d = 64'b0;
                ADDR_OUT_STS: d_out_d = {63'b0, out_full_q};
                default:      d_out_d = d_out_q;
            endcase
        end

        // Capture after the read-clear: a capture is only possible when the buffer was already empty.
        if (net_si && net_ri) begin
            in_buf_d  = net_di;
            in_full_d = 1'b1;
        end

        if (net_so) begin
            out_full_d = 1'b0;
        end

        // Pre-edge out_full gates the write, so a write colliding with a send is dropped.
        if (cpu_wr && (addr == ADDR_OUT_BUF) && !out_full_q) begin
            out_buf_d  = d_in;
            out_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_buf_q   <= 64'b0;
            in_full_q  <= 1'b0;
            out_buf_q  <= 64'b0;
            out_full_q <= 1'b0;
            d_out_q    <= 64'b0;
        end else begin
            in_buf_q   <= in_buf_d;
            in_full_q  <= in_full_d;
            out_buf_q  <= out_buf_d;
            out_full_q <= out_full_d;
            d_out_q    <= d_out_d;
        end
    end

endmodule

// File: tb/tb_cardinal_nic.sv
// Self-checking bench for cardinal_nic: CPU reads and router egress packets are scoreboarded.
module tb_cardinal_nic;

    logic        clk;
    logic        rst;
    logic [1:0]  addr;
    logic [0:63] d_in;
    logic [0:63] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_si;
    logic        net_ri;
    logic [0:63] net_di;
    logic        net_so;
    logic        net_ro;
    logic [0:63] net_do;
    logic        net_polarity;

    int checks   = 0;
    int failures = 0;
    int sends    = 0;

    logic [0:63] rd_q[$];
    logic [0:63] pkt_q[$];
    logic [0:63] rexp;
    logic [0:63] pexp;

    cardinal_nic dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Egress scoreboard: every send seen by the router must match the oldest accepted packet.
    always @(negedge clk) begin
        if (rst && net_so) begin
            sends++;
            checks++;
            if (pkt_q.size() == 0) begin
                failures++;
                $display("FAIL egress_unexpected: net_do=%h sent with no packet pending", net_do);
            end else begin
                pexp = pkt_q.pop_front();
                if (net_do !== pexp) begin
                    failures++;
                    $display("FAIL egress_data: net_do=%h expected=%h", net_do, pexp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_read(input logic [1:0] a, input logic [0:63] exp);
        addr    = a;
        nicEn   = 1'b1;
        nicWrEn = 1'b0;
        rd_q.push_back(exp);
        step();
        nicEn   = 1'b0;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [0:63] v, input bit accepted);
        addr    = a;
        nicEn   = 1'b1;
        nicWrEn = 1'b1;
        d_in    = v;
        if (accepted) pkt_q.push_back(v);
        step();
        nicEn   = 1'b0;
        nicWrEn = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; net_si = 1'b1; net_di = 64'h1234_5678_9ABC_DEF0;
        nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = 64'h8765_4321_0FED_CBA9;
        net_ro = 1'b1; net_polarity = 1'b1;
        repeat (3) step();
        checks++;
        if (d_out !== 64'b0) begin failures++; $display("FAIL reset_d_out: got=%h expected=0", d_out); end
        checks++;
        if (net_ri !== 1'b1) begin failures++; $display("FAIL reset_net_ri: got=%b expected=1", net_ri); end
        checks++;
        if (net_so !== 1'b0) begin failures++; $display("FAIL reset_net_so: got=%b expected=0", net_so); end
        net_si = 1'b0; nicEn = 1'b0; nicWrEn = 1'b0; net_ro = 1'b0;
        rst = 1'b1;
        cpu_read(2'b01, 64'b0);
        rexp = rd_q.pop_front(); checks++;
        if (d_out !== rexp) begin failures++; $display("FAIL reset_in_status: d_out=%h expected=%h", d_out, rexp); end
        cpu_read(2'b11, 64'b0);
        rexp = rd_q.pop_front(); checks++;
        if (d_out !== rexp) begin failures++; $display("FAIL reset_out_status: d_out=%h expected=%h", d_out, rexp); end
    endtask

    task automatic test_ingress();
        logic [0:63] p1;
        logic [0:63] p2;
        p1 = 64'hDEAD_BEEF_0000_0001;
        p2 = 64'h0123_4567_89AB_CDEF;
        net_si = 1'b1; net_di = p1;
        step();
        net_si = 1'b0;
        checks++;
        if (net_ri !== 1'b0) begin failures++; $display("FAIL ingress_ri_full: got=%b expected=0", net_ri); end
        cpu_read(2'b01, 64'd1);
        rexp = rd_q.pop_front(); checks++;
        if (d_out !== rexp) begin failures++; $display("FAIL ingress_status_full: d_out=%h expected=%h", d_out, rexp); end
        cpu_read(2'b00, p1);
        rexp = rd_q.pop_front(); checks++;
        if (d_out !== rexp) begin failures++; $display("FAIL ingress_data: d_out=%h expected=%h", d_out, rexp); end
        checks++;
        if (net_ri !== 1'b1) begin failures++; $display("FAIL ingress_ri_after_read: got=%b expected=1", net_ri); end
        // Earliest possible recapture: the cycle right after the freeing read.
        net_si = 1'b1; net_di = p2;
        step();
        net_si = 1'b0;
        checks++;
        if (net_ri !== 1'b0) begin failures++; $display("FAIL ingress_recapture: net_ri=%b expected=0", net_ri); end
        cpu_read(2'b00, p2);
        rexp = rd_q.pop_front(); checks++;
        if (d_out !== rexp) begin failures++; $display("FAIL ingress_data2: d_out=%h expected=%h", d_out, rexp); end
        cpu_read(2'b00, p2);
        rexp = rd_q.pop_front(); checks++;
        if (d_out !== rexp) begin failures++; $display("FAIL ingress_stale: d_out=%h expected=%h", d_out, rexp); end
        cpu_read(2'b01, 64'd0);
        rexp = rd_q.pop_front(); checks++;
        if (d_out !== rexp) begin failures++; $display("FAIL ingress_status_empty: d_out=%h expected=%h", d_out, rexp); end
    endtask

    task automatic test_egress();
        int s0;
        cpu_write(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        cpu_read(2'b11, 64'd0);
        rexp = rd_q.pop_front(); checks++;
        if (d_out !== rexp) begin failures++; $display("FAIL egress_bad_addr_write: d_out=%h expected=%h", d_out, rexp); end
        cpu_read(2'b10, 64'd0);
        rexp = rd_q.pop_front(); checks++;
        if (d_out !== rexp) begin failures++; $display("FAIL egress_read_out_buf: d_out=%h expected=%h", d_out, rexp); end
        net_ro = 1'b1; net_polarity = 1'b1;
        s0 = sends;
        cpu_write(2'b10, 64'h8000_0000_0000_00AA, 1'b1);
        repeat (4) step();
        checks++;
        if (sends - s0 != 1) begin failures++; $display("FAIL egress_send_count: sends=%0d expected=1", sends - s0); end
        cpu_read(2'b11, 64'd0);
        rexp = rd_q.pop_front(); checks++;
        if (d_out !== rexp) begin failures++; $display("FAIL egress_status_after: d_out=%h expected=%h", d_out, rexp); end
    endtask

    task automatic test_overflow();
        int s0;
        logic [0:63] a;
        logic [0:63] b;
        a = 64'h8000_0000_0000_0A0A;
        b = 64'h0000_0000_0000_0B0B;
        net_ro = 1'b0;
        s0 = sends;
        cpu_write(2'b10, a, 1'b1);
        cpu_write(2'b10, b, 1'b0);
        checks++;
        if (net_do !== a) begin failures++; $display("FAIL overflow_hold: net_do=%h expected=%h", net_do, a); end
        cpu_read(2'b11, 64'd1);
        rexp = rd_q.pop_front(); checks++;
        if (d_out !== rexp) begin failures++; $display("FAIL overflow_status: d_out=%h expected=%h", d_out, rexp); end
        net_polarity = a[0]; net_ro = 1'b1;
        repeat (4) step();
        checks++;
        if (sends - s0 != 1) begin failures++; $display("FAIL overflow_send_count: sends=%0d expected=1", sends - s0); end
        net_ro = 1'b0;
    endtask

    task automatic test_polarity();
        int s0;
        logic exp_first;
        logic exp_second;
`ifdef NIC_POLARITY_EN
        exp_first = 1'b0; exp_second = 1'b1;
`else
        exp_first = 1'b1; exp_second = 1'b0;
`endif
        net_ro = 1'b0;
        s0 = sends;
        cpu_write(2'b10, 64'h0000_0000_0000_0055, 1'b1);
        net_polarity = 1'b1; net_ro = 1'b1;
        #1;
        checks++;
        if (net_so !== exp_first) begin failures++; $display("FAIL polarity_phase1: net_so=%b expected=%b", net_so, exp_first); end
        step();
        net_polarity = 1'b0;
        #1;
        checks++;
        if (net_so !== exp_second) begin failures++; $display("FAIL polarity_phase0: net_so=%b expected=%b", net_so, exp_second); end
        step();
        net_ro = 1'b0;
        step();
        checks++;
        if (sends - s0 != 1) begin failures++; $display("FAIL polarity_send_count: sends=%0d expected=1", sends - s0); end
    endtask

    task automatic test_collision();
        int s0;
        net_ro = 1'b0; net_polarity = 1'b1;
        s0 = sends;
        cpu_write(2'b10, 64'h8000_0000_0000_0011, 1'b1);
        addr = 2'b10; nicEn = 1'b1; nicWrEn = 1'b1; d_in = 64'h8000_0000_0000_00CC;
        net_ro = 1'b1;
        #1;
        checks++;
        if (net_so !== 1'b1) begin failures++; $display("FAIL collision_send: net_so=%b expected=1", net_so); end
        step();
        nicEn = 1'b0; nicWrEn = 1'b0;
        cpu_read(2'b11, 64'd0);
        rexp = rd_q.pop_front(); checks++;
        if (d_out !== rexp) begin failures++; $display("FAIL collision_write_dropped: d_out=%h expected=%h", d_out, rexp); end
        net_ro = 1'b0;
        cpu_write(2'b10, 64'h8000_0000_0000_0022, 1'b1);
        net_ro = 1'b1;
        cpu_read(2'b11, 64'd1);
        rexp = rd_q.pop_front(); checks++;
        if (d_out !== rexp) begin failures++; $display("FAIL collision_status_in_send: d_out=%h expected=%h", d_out, rexp); end
        cpu_read(2'b11, 64'd0);
        rexp = rd_q.pop_front(); checks++;
        if (d_out !== rexp) begin failures++; $display("FAIL collision_status_after: d_out=%h expected=%h", d_out, rexp); end
        checks++;
        if (sends - s0 != 2) begin failures++; $display("FAIL collision_send_count: sends=%0d expected=2", sends - s0); end
        net_ro = 1'b0;
    endtask

    task automatic test_back_to_back();
        int s0;
        logic [0:63] v;
        s0 = sends;
        net_ro = 1'b1;
        for (int i = 0; i < 4; i++) begin
            v = {$urandom, $urandom};
            net_si = 1'b1; net_di = v;
            step();
            net_si = 1'b0;
            cpu_read(2'b00, v);
            rexp = rd_q.pop_front(); checks++;
            if (d_out !== rexp) begin failures++; $display("FAIL b2b_ingress[%0d]: d_out=%h expected=%h", i, d_out, rexp); end
            net_polarity = v[0];
            cpu_write(2'b10, v, 1'b1);
            step();
        end
        net_ro = 1'b0;
        step();
        checks++;
        if (sends - s0 != 4 || pkt_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_egress: sends=%0d pending=%0d expected 4 and 0", sends - s0, pkt_q.size());
        end
    endtask

    task automatic test_async_reset();
        logic [0:63] r;
        r = 64'h8000_0000_0000_0077;
        net_ro = 1'b0;
        cpu_write(2'b10, r, 1'b0);
        net_si = 1'b1; net_di = 64'h5555_AAAA_5555_AAAA;
        step();
        net_si = 1'b0;
        cpu_read(2'b01, 64'd1);
        rexp = rd_q.pop_front(); checks++;
        if (d_out !== rexp) begin failures++; $display("FAIL areset_pre_status: d_out=%h expected=%h", d_out, rexp); end
        net_ro = 1'b1; net_polarity = r[0];
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (net_so !== 1'b0 || net_ri !== 1'b1 || d_out !== 64'b0) begin
            failures++;
            $display("FAIL areset_immediate: net_so=%b net_ri=%b d_out=%h expected 0 1 0", net_so, net_ri, d_out);
        end
        step();
        rst = 1'b1;
        cpu_read(2'b11, 64'd0);
        rexp = rd_q.pop_front(); checks++;
        if (d_out !== rexp) begin failures++; $display("FAIL areset_out_status: d_out=%h expected=%h", d_out, rexp); end
        cpu_read(2'b01, 64'd0);
        rexp = rd_q.pop_front(); checks++;
        if (d_out !== rexp) begin failures++; $display("FAIL areset_in_status: d_out=%h expected=%h", d_out, rexp); end
        net_ro = 1'b0;
    endtask

    initial begin
        rst = 1'b0; addr = 2'b00; d_in = 64'b0; nicEn = 1'b0; nicWrEn = 1'b0;
        net_si = 1'b0; net_di = 64'b0; net_ro = 1'b0; net_polarity = 1'b0;
        #1;
        test_reset();
        test_ingress();
        test_egress();
        test_overflow();
        test_polarity();
        test_collision();
        test_back_to_back();
        test_async_reset();
        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
